// File: rtl/huff_block_sequencer_if.sv
// Bus between the block sequencer, the bit buffer, the Huffman decoder and the coefficient sink.
// master is the sequencer side, slave is the environment side.
`ifndef CH
`define CH 3
`endif

interface huff_block_sequencer_if #(parameter int NUM_CH = `CH);
    localparam int CHW = $clog2(NUM_CH + 1);

    logic [31:0]    bits;
    logic           bits_valid;
    logic           consume;
    logic [5:0]     consume_len;
    logic           dec_valid_in;
    logic           dec_freq;
    logic [CHW-1:0] dec_ch;
    logic [15:0]    dec_code;
    logic [3:0]     dec_run;
    logic [3:0]     dec_vli_size;
    logic [4:0]     dec_code_size;
    logic           dec_valid_out;
    logic           coef_valid;
    logic           coef_ready;
    logic [5:0]     coef_idx;
    logic [15:0]    coef_val;
    logic [CHW-1:0] coef_ch;
    logic           block_done;
    logic           mcu_done;
    logic           error;

    modport master (
        input  bits, bits_valid, dec_run, dec_vli_size, dec_code_size, dec_valid_out, coef_ready,
        output consume, consume_len, dec_valid_in, dec_freq, dec_ch, dec_code,
               coef_valid, coef_idx, coef_val, coef_ch, block_done, mcu_done, error
    );

    modport slave (
        output bits, bits_valid, dec_run, dec_vli_size, dec_code_size, dec_valid_out, coef_ready,
        input  consume, consume_len, dec_valid_in, dec_freq, dec_ch, dec_code,
               coef_valid, coef_idx, coef_val, coef_ch, block_done, mcu_done, error
    );
endinterface

// File: rtl/huff_block_sequencer.sv
// Walks the Huffman decoder through one 8x8 block per channel: DC with prediction, then AC
// run/size symbols with EOB/ZRL, emitting only DC and nonzero AC coefficients.
`ifndef CH
`define CH 3
`endif

module huff_block_sequencer #(
    parameter int NUM_CH = `CH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    huff_block_sequencer_if.master        bus
);
    localparam int CHW = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {IDLE, DC, AC, ERR} state_t;

    state_t                     state;
    logic [CHW-1:0]             ch;
    logic [6:0]                 idx;
    logic [NUM_CH-1:0][15:0]    pred;

    logic [31:0] win;
    logic [15:0] mag, vli, dc_sum;
    logic [6:0]  tgt;
    logic        active, slot_free, hit, miss, eob, zrl, range_bad, err_now, accept;

    always_comb begin
        win = bus.bits >> bus.dec_code_size;
        mag = '0;
        // first VLI bit after the code is the magnitude MSB
        for (int j = 0; j < 16; j++) begin
            int k;
            k = int'(bus.dec_vli_size) - 1 - j;
            if (j < int'(bus.dec_vli_size)) mag[j] = win[k[4:0]];
        end
        if (bus.dec_vli_size == 4'd0)
            vli = '0;
        else if (mag[bus.dec_vli_size - 4'd1])
            vli = mag;
        else
            vli = mag - ((16'd1 << bus.dec_vli_size) - 16'd1);
    end

    assign active    = (state == DC) || (state == AC);
    assign slot_free = !bus.coef_valid || bus.coef_ready;
    assign eob       = (bus.dec_run == 4'd0)  && (bus.dec_vli_size == 4'd0);
    assign zrl       = (bus.dec_run == 4'd15) && (bus.dec_vli_size == 4'd0);
    assign tgt       = idx + {3'd0, bus.dec_run};
    assign dc_sum    = pred[ch] + vli;

    assign range_bad = (state == AC) &&
                       ((bus.dec_vli_size == 4'd0 && !eob && !zrl) ||
                        (zrl && (idx + 7'd16 > 7'd64)) ||
                        (bus.dec_vli_size != 4'd0 && tgt > 7'd63));

    assign miss    = bus.dec_valid_in && !bus.dec_valid_out;
    assign hit     = active && bus.bits_valid && bus.dec_valid_out && slot_free;
    assign err_now = miss || (hit && range_bad);
    assign accept  = hit && !range_bad;

    assign bus.dec_valid_in = active && bus.bits_valid;
    assign bus.dec_freq     = (state == AC);
    assign bus.dec_ch       = ch;
    assign bus.dec_code     = bus.bits[15:0];
    assign bus.consume      = accept;
    assign bus.consume_len  = {1'b0, bus.dec_code_size} + {2'b0, bus.dec_vli_size};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            ch             <= '0;
            idx            <= '0;
            pred           <= '0;
            bus.coef_valid <= 1'b0;
            bus.coef_idx   <= '0;
            bus.coef_val   <= '0;
            bus.coef_ch    <= '0;
            bus.block_done <= 1'b0;
            bus.mcu_done   <= 1'b0;
            bus.error      <= 1'b0;
        end else if (start) begin
            state          <= DC;
            ch             <= '0;
            idx            <= '0;
            pred           <= '0;
            bus.coef_valid <= 1'b0;
            bus.block_done <= 1'b0;
            bus.mcu_done   <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            bus.block_done <= 1'b0;
            bus.mcu_done   <= 1'b0;
            if (bus.coef_valid && bus.coef_ready) bus.coef_valid <= 1'b0;

            if (err_now) begin
                bus.error <= 1'b1;
                state     <= ERR;
            end else if (accept) begin
                if (state == DC) begin
                    pred[ch]       <= dc_sum;
                    bus.coef_valid <= 1'b1;
                    bus.coef_idx   <= 6'd0;
                    bus.coef_val   <= dc_sum;
                    bus.coef_ch    <= ch;
                    idx            <= 7'd1;
                    state          <= AC;
                end else if (zrl) begin
                    idx <= idx + 7'd16;
                end else begin
                    if (!eob) begin
                        bus.coef_valid <= 1'b1;
                        bus.coef_idx   <= tgt[5:0];
                        bus.coef_val   <= vli;
                        bus.coef_ch    <= ch;
                        idx            <= tgt + 7'd1;
                    end
                    // EOB or the 64th coefficient closes the block
                    if (eob || tgt == 7'd63) begin
                        bus.block_done <= 1'b1;
                        idx            <= '0;
                        state          <= DC;
                        if (ch == CHW'(NUM_CH - 1)) begin
                            ch           <= '0;
                            bus.mcu_done <= 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
